// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU control path and a DMA/loader port onto one req/ack memory port.
// The CPU is favoured, but DMA gets a bounded streak guarantee; a stuck access times out.
module mem_port_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MAX_CPU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic          CLK,
  input  logic          reset,
  // CPU control path
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  output logic          cpu_err,
  // DMA / program loader
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          dma_err,
  // Memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] StreakMax = 4'(MAX_CPU_STREAK);
  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);
  localparam bit         TimeoutEn = (TIMEOUT != 0);

  state_e          state_q, state_d;
  logic            owner_dma_q, owner_dma_d;
  logic [3:0]      streak_q, streak_d;
  logic [7:0]      timer_q, timer_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic cpu_req;
  logic grant_dma;
  logic grant_cpu;
  logic timed_out;
  logic in_done;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign grant_dma = dma_req && (!cpu_req || (streak_q == StreakMax));
  assign grant_cpu = cpu_req && !grant_dma;
  assign timed_out = TimeoutEn && (timer_q == TimerLast);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_dma_q <= 1'b0;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dma_q <= owner_dma_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_dma_d = owner_dma_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_dma) begin
          owner_dma_d = 1'b1;
          mem_we_d    = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          streak_d    = '0;
          timer_d     = '0;
          mem_req_d   = 1'b1;
          state_d     = StBusy;
        end else if (grant_cpu) begin
          owner_dma_d = 1'b0;
          // A simultaneous rd+wr is resolved as a write.
          mem_we_d    = cpu_wr;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          if (!dma_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 4'd1;
          end
          timer_d   = '0;
          mem_req_d = 1'b1;
          state_d   = StBusy;
        end
      end

      StBusy: begin
        if (mem_ack) begin
          rdata_d   = mem_we_q ? '0 : mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else if (timed_out) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      StDone: begin
        // One idle-side cycle so the CPU control unit can advance before re-arbitration.
        state_d = StIdle;
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign in_done   = (state_q == StDone);

  assign cpu_done  = in_done & ~owner_dma_q;
  assign cpu_err   = cpu_done & err_q;
  assign cpu_rdata = cpu_done ? rdata_q : '0;

  assign dma_done  = in_done & owner_dma_q;
  assign dma_err   = dma_done & err_q;
  assign dma_rdata = dma_done ? rdata_q : '0;

  // Gated by reset so every output reads 0 while reset is held.
  assign cpu_stall = reset & cpu_req & ~cpu_done;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle CPU between two requesters: the CPU control path (fetch, LW and SW) and a DMA/program-loader port.
- Sits between the control unit's MemRead/MemWrite/IorD-selected address and the external memory.
- The memory handshake is req/ack with variable latency.
- Provides a stall to the control unit so it holds its current state until the access completes.
- Adds bounded-starvation fairness for DMA and a bus-timeout error.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while DMA waits (1..15).
- TIMEOUT, 16, cycles to wait for mem_ack before aborting; 0 disables the timeout (max 255).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU read request (MemRead).
- cpu_wr  in  1  CPU write request (MemWrite).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse for the CPU.
- cpu_stall  out  1  combinational: (cpu_rd|cpu_wr) & ~cpu_done.
- cpu_err  out  1  timeout flag for the CPU; pulses with cpu_done.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_rdata  out  DW  DMA read data; valid while dma_done=1.
- dma_done  out  1  one-cycle completion pulse for DMA.
- dma_err  out  1  timeout flag for DMA; pulses with dma_done.
- mem_req  out  1  memory request; held until ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  memory acknowledge; single-cycle pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=CPU, streak=0, timer=0.
  - All outputs 0; mem_req drops immediately, even mid-transfer.
  - An aborted transfer is never completed.
- States: IDLE, BUSY, DONE. All memory-side outputs are registered.
- IDLE:
  - Requests: cpu_req = cpu_rd|cpu_wr; dma_req as given.
  - Grant DMA if dma_req && (!cpu_req || streak==MAX_CPU_STREAK); otherwise grant CPU if cpu_req.
  - On grant: latch addr, wdata and we into mem_* registers; set owner; timer=0; go BUSY.
  - CPU with cpu_rd and cpu_wr both high: treated as a write.
- Streak counter:
  - On a CPU grant, streak increments (saturating) if dma_req=1, else it is cleared.
  - On a DMA grant, streak is cleared.
- BUSY:
  - mem_req=1; addr, we and wdata stay stable.
  - If mem_ack=1: capture mem_rdata (captured value is 0 for writes), go DONE.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: go DONE with the error flag set and captured data 0.
  - Else timer increments.
  - Requester inputs are ignored in BUSY; requester changes mid-transfer have no effect.
- DONE:
  - mem_req=0.
  - Owner's done=1 and rdata=captured data; owner's err=1 only if the transfer was aborted.
  - Non-owner outputs are 0.
  - Next state: IDLE.
  - The DONE cycle lets the CPU control unit leave its state before IDLE re-samples requests, so there is no double grant.
- Latency: request in IDLE at cycle N, mem_req high at N+1, ack at N+k (k≥1), done at N+k+1. Minimum 2 cycles, 1-cycle gap back to IDLE.
- A mem_ack outside BUSY is ignored.
- rdata outputs hold 0 when done=0.

Test Plan:
- CPU read at 0x100, memory acks 1 cycle after mem_req with 0xDEADBEEF -> mem_req high 1 cycle with mem_we=0, cpu_done pulses once with cpu_rdata=0xDEADBEEF, cpu_stall high until that cycle.
- CPU write 0x55AA55AA to 0x200 while DMA idle -> mem_we=1, mem_wdata=0x55AA55AA; cpu_done pulse; cpu_err=0; dma_* outputs stay 0.
- cpu_rd and dma_req held continuously, MAX_CPU_STREAK=4, ack latency 2 -> grant order CPU,CPU,CPU,CPU,DMA, repeating; DMA never waits more than 4 transfers.
- TIMEOUT=16, mem_ack never asserted for a DMA read -> mem_req high exactly 16 cycles, then dma_done=dma_err=1 with dma_rdata=0, then IDLE.
- reset driven low in the 2nd BUSY cycle of a CPU write -> mem_req and all outputs 0 immediately; after release, no done pulse; the next request starts fresh.
- Late mem_ack arriving in IDLE after a timeout -> ignored; no done pulse, no state change.
